lcd_frame_size_calc: RTL
========================

// Module: lcd_frame_size_calc
// PURPOSE
//   Computes the SDRAM frame size and the SD-card sector count for any LCD resolution and pixel depth,
//   replacing the fixed LCD-ID lookup table with a sequential multiplier and a ceiling divide.
//   Sits between the LCD ID/timing decode and the SD-read / SDRAM-write controllers.
//   Recomputes on request, or automatically when the resolution or pixel depth inputs change.
// PARAMETERS
//   H_W         11  width of h_pixel
//   V_W         11  width of v_pixel; also the number of multiplier iterations
//   ADDR_W      24  width of sdram_max_addr
//   SEC_W       16  width of sd_sec_num
//   SEC_SHIFT    9  log2(sector bytes); 9 = 512 B
//   EXTRA_SEC    1  guard sectors added to every sector count
//   AUTO_RECALC  1  1 = self-start in IDLE when the inputs differ from the last latched inputs
// PORTS
//   clk             in   1      system clock
//   rst_n           in   1      asynchronous reset, active low
//   h_pixel         in   H_W    horizontal resolution in pixels
//   v_pixel         in   V_W    vertical resolution in pixels
//   pix_bytes       in   3      bytes per pixel; legal range 1..4
//   calc_start      in   1      single-cycle request; sampled only in IDLE
//   calc_busy       out  1      high from the cycle after a start is accepted until done
//   calc_done       out  1      1-cycle pulse; coincides with the new output values
//   size_valid      out  1      outputs hold a completed result
//   size_err        out  1      last result was saturated or had illegal inputs
//   sdram_max_addr  out  ADDR_W h_pixel*v_pixel (one SDRAM word per pixel)
//   sd_sec_num      out  SEC_W  ceil(h*v*pix_bytes / 2^SEC_SHIFT) + EXTRA_SEC
// BEHAVIOUR
//   Reset: every output is 0; the FSM enters IDLE; latched inputs are 0. Reset is honoured in any state
//     and aborts an in-flight calculation with no done pulse.
//   FSM states and transitions:
//     IDLE -> MUL when calc_start=1, or (AUTO_RECALC=1 and {h,v,pix_bytes} != latched values).
//       The accepting edge latches h_pixel, v_pixel and pix_bytes.
//     MUL: shift-add multiplier, one bit of v per cycle, V_W cycles. Product width is H_W+V_W.
//     BYTE: pixels*pix_bytes, shift-add over 3 bits, 3 cycles. Product width is H_W+V_W+3.
//     SEC: sec = (bytes >> SEC_SHIFT) + (|bytes[SEC_SHIFT-1:0]) + EXTRA_SEC, 1 cycle.
//     UPD: registers the outputs and pulses calc_done, then returns to IDLE.
//   Latency: calc_done is high in the cycle after clock edge V_W+5, counting the accepting edge as edge 0.
//     With the default parameters that is 16 edges.
//   Output holding and flags:
//     - Outputs keep their previous values while busy.
//     - size_valid stays at its previous value while busy and is set at UPD.
//   Starts during calculation:
//     - calc_start is ignored while calc_busy=1.
//     - Input changes while busy are not lost. With AUTO_RECALC=1, IDLE starts a new calculation
//       on the cycle after UPD.
//   Saturation:
//     - pixels > 2^ADDR_W-1 -> sdram_max_addr = all ones and size_err=1.
//     - sec > 2^SEC_W-1 -> sd_sec_num = all ones and size_err=1.
//   Illegal inputs: h=0, v=0, pix_bytes=0 or pix_bytes>4 -> both outputs 0, size_err=1, size_valid=1,
//     with the normal latency and done pulse.
//   size_err is cleared at UPD when the new result is legal and unsaturated.
// TESTING
//   480x272, pix_bytes=3, start -> done at edge 16; max_addr=130560, sec=766, err=0.
//   800x480x3 -> 384000 / 2251; 1024x600x3 -> 614400 / 3601; 1280x800x2 -> 1024000 / 4001.
//   100x3x1 (300 B) -> max_addr=300, sec=2 (ceil rounds up plus the guard sector).
//   SEC_W=12, 1280x800x3 -> sec saturates at 4095, size_err=1, max_addr=1024000.
//   Pulse start at edges 0 and 5 -> exactly one done pulse. Change h while busy with AUTO=1
//     -> a second done pulse with the new result.
//   Assert rst_n low mid-MUL -> outputs 0, no done pulse. Then pix_bytes=0 -> err=1, outputs 0.

Source files
------------

// File: rtl/lcd_frame_size_calc_if.sv
// Request/result bundle between the LCD ID/timing decode and the frame size calculator.
// The master drives resolution, pixel depth and start; the slave returns status and sizes.
interface lcd_frame_size_calc_if #(
    parameter int H_W    = 11,
    parameter int V_W    = 11,
    parameter int ADDR_W = 24,
    parameter int SEC_W  = 16
) ();
    logic [H_W-1:0]    h_pixel;
    logic [V_W-1:0]    v_pixel;
    logic [2:0]        pix_bytes;
    logic              calc_start;
    logic              calc_busy;
    logic              calc_done;
    logic              size_valid;
    logic              size_err;
    logic [ADDR_W-1:0] sdram_max_addr;
    logic [SEC_W-1:0]  sd_sec_num;

    modport master (
        output h_pixel, v_pixel, pix_bytes, calc_start,
        input  calc_busy, calc_done, size_valid, size_err, sdram_max_addr, sd_sec_num
    );

    modport slave (
        input  h_pixel, v_pixel, pix_bytes, calc_start,
        output calc_busy, calc_done, size_valid, size_err, sdram_max_addr, sd_sec_num
    );
endinterface

// File: rtl/lcd_frame_size_calc.sv
// Frame size calculator: h*v pixels via a shift-add multiplier, then bytes and SD sectors
// (ceiling divide by the sector size plus guard sectors), with saturation and input checks.
module lcd_frame_size_calc #(
    parameter int H_W         = 11,
    parameter int V_W         = 11,
    parameter int ADDR_W      = 24,
    parameter int SEC_W       = 16,
    parameter int SEC_SHIFT   = 9,
    parameter int EXTRA_SEC   = 1,
    parameter int AUTO_RECALC = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lcd_frame_size_calc_if.slave  bus
);
    localparam int P_W   = H_W + V_W;
    localparam int B_W   = P_W + 3;
    localparam int CNT_W = $clog2(V_W) + 1;
    localparam logic [63:0] ADDR_MAX = (64'd1 << ADDR_W) - 64'd1;
    localparam logic [63:0] SEC_MAX  = (64'd1 << SEC_W) - 64'd1;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        BYTE,
        SEC,
        UPD
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [H_W-1:0]     h_lat_reg;
    logic [V_W-1:0]     v_lat_reg;
    logic [2:0]         pb_lat_reg;

    logic [P_W-1:0]     mcand_reg;
    logic [V_W-1:0]     mplier_reg;
    logic [P_W-1:0]     acc_reg;

    logic [B_W-1:0]     bmcand_reg;
    logic [2:0]         bmul_reg;
    logic [B_W-1:0]     bacc_reg;

    logic [B_W:0]       sec_reg;

    logic               busy_reg;
    logic               done_reg;
    logic               valid_reg;
    logic               err_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [SEC_W-1:0]   sec_out_reg;

    logic [P_W-1:0]     mul_sum;
    logic [B_W-1:0]     byte_sum;
    logic [B_W:0]       sec_calc;
    logic               inputs_changed;
    logic               start_req;
    logic               inputs_legal;
    logic               addr_sat;
    logic               sec_sat;

    assign mul_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign byte_sum = bacc_reg + (bmul_reg[0] ? bmcand_reg : '0);

    // Ceiling divide: any nonzero remainder below the sector boundary costs one more sector.
    assign sec_calc = (B_W+1)'(bacc_reg >> SEC_SHIFT)
                    + (B_W+1)'(|bacc_reg[SEC_SHIFT-1:0])
                    + (B_W+1)'(EXTRA_SEC);

    assign inputs_changed = {bus.h_pixel, bus.v_pixel, bus.pix_bytes}
                         != {h_lat_reg, v_lat_reg, pb_lat_reg};
    assign start_req      = bus.calc_start || ((AUTO_RECALC != 0) && inputs_changed);

    assign inputs_legal = (h_lat_reg != '0) && (v_lat_reg != '0)
                       && (pb_lat_reg != 3'd0) && (pb_lat_reg <= 3'd4);
    assign addr_sat     = 64'(acc_reg) > ADDR_MAX;
    assign sec_sat      = 64'(sec_reg) > SEC_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            h_lat_reg   <= '0;
            v_lat_reg   <= '0;
            pb_lat_reg  <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            bmcand_reg  <= '0;
            bmul_reg    <= '0;
            bacc_reg    <= '0;
            sec_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            addr_reg    <= '0;
            sec_out_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        h_lat_reg  <= bus.h_pixel;
                        v_lat_reg  <= bus.v_pixel;
                        pb_lat_reg <= bus.pix_bytes;
                        mcand_reg  <= P_W'(bus.h_pixel);
                        mplier_reg <= bus.v_pixel;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= MUL;
                    end
                end
                MUL: begin
                    acc_reg    <= mul_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(V_W - 1)) begin
                        // Final partial product feeds the byte multiplier directly.
                        bmcand_reg <= B_W'(mul_sum);
                        bmul_reg   <= pb_lat_reg;
                        bacc_reg   <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= BYTE;
                    end
                end
                BYTE: begin
                    bacc_reg   <= byte_sum;
                    bmcand_reg <= bmcand_reg << 1;
                    bmul_reg   <= bmul_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(2)) begin
                        cnt_reg   <= '0;
                        state_reg <= SEC;
                    end
                end
                SEC: begin
                    sec_reg   <= sec_calc;
                    state_reg <= UPD;
                end
                UPD: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b1;
                    if (!inputs_legal) begin
                        addr_reg    <= '0;
                        sec_out_reg <= '0;
                        err_reg     <= 1'b1;
                    end else begin
                        addr_reg    <= addr_sat ? '1 : ADDR_W'(acc_reg);
                        sec_out_reg <= sec_sat ? '1 : SEC_W'(sec_reg);
                        err_reg     <= addr_sat || sec_sat;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.calc_busy      = busy_reg;
    assign bus.calc_done      = done_reg;
    assign bus.size_valid     = valid_reg;
    assign bus.size_err       = err_reg;
    assign bus.sdram_max_addr = addr_reg;
    assign bus.sd_sec_num     = sec_out_reg;
endmodule
